// File: rtl/myriscv_alu_arbiter_if.sv
// Bus between two ALU requesters, the shared-ALU arbiter and one response consumer.
// A transfer happens on a rising edge when valid and ready are both high. Once a source
// raises valid, it holds valid and payload stable until that edge.
interface myriscv_alu_arbiter_if;
  logic [1:0]  req_valid_i;
  logic [5:0]  req0_operator_i;
  logic [5:0]  req1_operator_i;
  logic [31:0] req0_a_i;
  logic [31:0] req0_b_i;
  logic [31:0] req1_a_i;
  logic [31:0] req1_b_i;
  logic [1:0]  req_ready_o;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        rsp_id_o;
  logic [31:0] rsp_result_o;
  logic        rsp_cmp_o;
  logic        rsp_err_o;

  modport master (
    output req_valid_i, req0_operator_i, req1_operator_i,
           req0_a_i, req0_b_i, req1_a_i, req1_b_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o, rsp_cmp_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req0_operator_i, req1_operator_i,
           req0_a_i, req0_b_i, req1_a_i, req1_b_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o, rsp_cmp_o, rsp_err_o
  );
endinterface

// File: rtl/myriscv_alu_arbiter.sv
// Two-requester arbiter sharing one combinational ALU: IDLE grants, EXEC computes,
// RESP holds the registered result until the consumer takes it.
module myriscv_alu (
  input  logic [5:0]  operator_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  output logic [31:0] result_o,
  output logic        comparison_result_o
);
  always_comb begin
    result_o            = '0;
    comparison_result_o = 1'b0;
    case (operator_i)
      6'b011000: result_o = operand_a_i + operand_b_i;
      6'b011001: result_o = operand_a_i - operand_b_i;
      6'b101111: result_o = operand_a_i ^ operand_b_i;
      6'b101110: result_o = operand_a_i | operand_b_i;
      6'b010101: result_o = operand_a_i & operand_b_i;
      6'b100100: result_o = $unsigned($signed(operand_a_i) >>> operand_b_i[4:0]);
      6'b100101: result_o = operand_a_i >> operand_b_i[4:0];
      6'b100111: result_o = operand_a_i << operand_b_i[4:0];
      6'b000000, 6'b000010: comparison_result_o = $signed(operand_a_i) < $signed(operand_b_i);
      6'b000001, 6'b000011: comparison_result_o = operand_a_i < operand_b_i;
      6'b001010: comparison_result_o = $signed(operand_a_i) >= $signed(operand_b_i);
      6'b001011: comparison_result_o = operand_a_i >= operand_b_i;
      6'b001100: comparison_result_o = operand_a_i == operand_b_i;
      6'b001101: comparison_result_o = operand_a_i != operand_b_i;
      default: ;
    endcase
    // Comparison codes return their flag zero-extended as the result as well.
    if (operator_i inside {6'b000000, 6'b000001, 6'b000010, 6'b000011,
                           6'b001010, 6'b001011, 6'b001100, 6'b001101}) begin
      result_o = {31'b0, comparison_result_o};
    end
  end
endmodule

module myriscv_alu_arbiter #(
  parameter bit CHECK_OP = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  myriscv_alu_arbiter_if.slave bus,
  output logic [1:0]           dbg_state_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        id_q, id_d;
  logic [31:0] res_q, res_d;
  logic        cmp_q, cmp_d, err_q, err_d, rid_q, rid_d;

  logic        gnt_id;
  logic [1:0]  ready;
  logic        hs;
  logic [5:0]  sel_op;
  logic [31:0] sel_a, sel_b;
  logic [31:0] alu_result;
  logic        alu_cmp;
  logic        op_bad;

  function automatic logic op_defined(input logic [5:0] op);
    return op inside {6'b011000, 6'b011001, 6'b101111, 6'b101110, 6'b010101,
                      6'b100100, 6'b100101, 6'b100111, 6'b000000, 6'b000001,
                      6'b001010, 6'b001011, 6'b000010, 6'b000011, 6'b001100, 6'b001101};
  endfunction

  myriscv_alu u_alu (
    .operator_i          (op_q),
    .operand_a_i         (a_q),
    .operand_b_i         (b_q),
    .result_o            (alu_result),
    .comparison_result_o (alu_cmp)
  );

  assign op_bad = CHECK_OP && !op_defined(op_q);

  always_comb begin
    // Priority pointer only breaks ties; a lone valid requester always wins.
    gnt_id = (bus.req_valid_i == 2'b11) ? prio_q : bus.req_valid_i[1];
    ready  = '0;
    if (state_q == IDLE && !rst_i && bus.req_valid_i[gnt_id]) ready[gnt_id] = 1'b1;
    hs     = |(ready & bus.req_valid_i);
    sel_op = gnt_id ? bus.req1_operator_i : bus.req0_operator_i;
    sel_a  = gnt_id ? bus.req1_a_i : bus.req0_a_i;
    sel_b  = gnt_id ? bus.req1_b_i : bus.req0_b_i;
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    res_d   = res_q;
    cmp_d   = cmp_q;
    err_d   = err_q;
    rid_d   = rid_q;
    case (state_q)
      IDLE: if (hs) begin
        op_d    = sel_op;
        a_d     = sel_a;
        b_d     = (sel_op inside {6'b100100, 6'b100101, 6'b100111}) ? {27'b0, sel_b[4:0]} : sel_b;
        id_d    = gnt_id;
        prio_d  = ~gnt_id;
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = op_bad ? '0 : alu_result;
        cmp_d   = op_bad ? 1'b0 : alu_cmp;
        err_d   = op_bad;
        rid_d   = id_q;
        state_d = RESP;
      end
      RESP: if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
      cmp_q   <= 1'b0;
      err_q   <= 1'b0;
      rid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      res_q   <= res_d;
      cmp_q   <= cmp_d;
      err_q   <= err_d;
      rid_q   <= rid_d;
    end
  end

  assign bus.req_ready_o  = ready;
  assign bus.rsp_valid_o  = (state_q == RESP);
  assign bus.rsp_id_o     = rid_q;
  assign bus.rsp_result_o = res_q;
  assign bus.rsp_cmp_o    = cmp_q;
  assign bus.rsp_err_o    = err_q;
  assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_myriscv_alu_arbiter.sv
// Bench for myriscv_alu_arbiter: a CHECK_OP=1 instance, plus a CHECK_OP=0 twin fed the same
// stimulus, with an expected-response queue filled at accept and drained at response.
module tb_myriscv_alu_arbiter;
  localparam int W = 35;
  localparam logic [5:0] OP_ADD = 6'b011000, OP_SUB = 6'b011001, OP_SRA = 6'b100100;
  localparam logic [5:0] OP_LTU = 6'b000001, OP_EQ = 6'b001100, OP_BAD = 6'b111111;

  logic [5:0] def_ops [16] = '{6'b011000, 6'b011001, 6'b101111, 6'b101110, 6'b010101, 6'b100100,
                               6'b100101, 6'b100111, 6'b000000, 6'b000001, 6'b001010, 6'b001011,
                               6'b000010, 6'b000011, 6'b001100, 6'b001101};

  logic clk = 1'b0;
  logic rst;
  logic [1:0] dbg_state, dbg_state_nc;
  int pass_cnt = 0;
  int check_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  logic [W-1:0] rsp_word;

  myriscv_alu_arbiter_if bus ();
  myriscv_alu_arbiter_if bus_nc ();

  always #5 clk = ~clk;

  myriscv_alu_arbiter #(.CHECK_OP(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .dbg_state_o(dbg_state));
  myriscv_alu_arbiter #(.CHECK_OP(1'b0)) dut_nc (
    .clk_i(clk), .rst_i(rst), .bus(bus_nc), .dbg_state_o(dbg_state_nc));

  assign bus_nc.req_valid_i     = bus.req_valid_i;
  assign bus_nc.req0_operator_i = bus.req0_operator_i;
  assign bus_nc.req1_operator_i = bus.req1_operator_i;
  assign bus_nc.req0_a_i        = bus.req0_a_i;
  assign bus_nc.req0_b_i        = bus.req0_b_i;
  assign bus_nc.req1_a_i        = bus.req1_a_i;
  assign bus_nc.req1_b_i        = bus.req1_b_i;
  assign bus_nc.rsp_ready_i     = bus.rsp_ready_i;
  assign rsp_word = {bus.rsp_id_o, bus.rsp_err_o, bus.rsp_cmp_o, bus.rsp_result_o};

  // Reference model: returns {err, cmp, result}.
  function automatic logic [33:0] alu_model(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input bit chk);
    logic [31:0] r;
    logic c, e, is_cmp;
    logic signed [31:0] sa, sb;
    sa = a; sb = b; r = '0; c = 1'b0; e = 1'b0; is_cmp = 1'b1;
    case (op)
      6'b011000: begin r = a + b;              is_cmp = 1'b0; end
      6'b011001: begin r = a - b;              is_cmp = 1'b0; end
      6'b101111: begin r = a ^ b;              is_cmp = 1'b0; end
      6'b101110: begin r = a | b;              is_cmp = 1'b0; end
      6'b010101: begin r = a & b;              is_cmp = 1'b0; end
      6'b100100: begin r = sa >>> b[4:0];      is_cmp = 1'b0; end
      6'b100101: begin r = a >> b[4:0];        is_cmp = 1'b0; end
      6'b100111: begin r = a << b[4:0];        is_cmp = 1'b0; end
      6'b000000, 6'b000010: c = (sa < sb);
      6'b000001, 6'b000011: c = (a < b);
      6'b001010: c = (sa >= sb);
      6'b001011: c = (a >= b);
      6'b001100: c = (a == b);
      6'b001101: c = (a != b);
      default:   begin e = chk;                is_cmp = 1'b0; end
    endcase
    if (is_cmp) r = {31'b0, c};
    return {e, c, r};
  endfunction

  task automatic set_req(input bit k, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    if (k) begin
      bus.req1_operator_i = op; bus.req1_a_i = a; bus.req1_b_i = b;
    end else begin
      bus.req0_operator_i = op; bus.req0_a_i = a; bus.req0_b_i = b;
    end
  endtask

  task automatic push_exp(input bit k);
    if (k) exp_q.push_back({1'b1, alu_model(bus.req1_operator_i, bus.req1_a_i, bus.req1_b_i, 1'b1)});
    else   exp_q.push_back({1'b0, alu_model(bus.req0_operator_i, bus.req0_a_i, bus.req0_b_i, 1'b1)});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, OP_ADD, 32'd1, 32'd2);
    set_req(1, OP_ADD, 32'd3, 32'd4);
    bus.req_valid_i = 2'b11;
    @(negedge clk); @(negedge clk); #1;
    check_cnt++; if (bus.req_ready_o !== 2'b00) $display("FAIL rst_ready: got %b expected 00", bus.req_ready_o); else pass_cnt++;
    check_cnt++; if (dbg_state !== 2'd0) $display("FAIL rst_state: got %0d expected 0", dbg_state); else pass_cnt++;
    bus.req_valid_i = 2'b00;
    @(negedge clk); rst = 1'b0; #1;
    check_cnt++;
    if ({bus.rsp_valid_o, rsp_word} !== '0) $display("FAIL rst_rsp: got %b_%h expected 0_0", bus.rsp_valid_o, rsp_word);
    else pass_cnt++;
  endtask

  task automatic test_single_add();
    @(negedge clk);
    bus.rsp_ready_i = 1'b1;
    set_req(0, OP_ADD, 32'd5, 32'd7);
    bus.req_valid_i = 2'b01; #1;
    check_cnt++; if (bus.req_ready_o !== 2'b01) $display("FAIL add_ready: got %b expected 01", bus.req_ready_o); else pass_cnt++;
    push_exp(0);
    @(negedge clk); bus.req_valid_i = 2'b00; #1;
    check_cnt++; if (bus.rsp_valid_o !== 1'b0) $display("FAIL add_exec_valid: got %b expected 0", bus.rsp_valid_o); else pass_cnt++;
    @(negedge clk); #1;
    check_cnt++;
    if (exp_q.size() == 0) $display("FAIL add_rsp: got %h expected <none queued>", rsp_word);
    else begin
      exp_v = exp_q.pop_front();
      if ({bus.rsp_valid_o, rsp_word} !== {1'b1, exp_v}) $display("FAIL add_rsp: got %b_%h expected 1_%h", bus.rsp_valid_o, rsp_word, exp_v);
      else pass_cnt++;
    end
    check_cnt++; if (bus.rsp_result_o !== 32'd12) $display("FAIL add_result: got %h expected 0000000c", bus.rsp_result_o); else pass_cnt++;
    @(negedge clk); #1;
    check_cnt++; if (bus.rsp_valid_o !== 1'b0) $display("FAIL add_rsp_done: got %b expected 0", bus.rsp_valid_o); else pass_cnt++;
  endtask

  task automatic test_contention();
    @(negedge clk);
    rst = 1'b1;
    set_req(0, OP_EQ, 32'd3, 32'd3);
    set_req(1, OP_SUB, 32'd3, 32'd5);
    bus.req_valid_i = 2'b11;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check_cnt++; if (bus.req_ready_o !== 2'b01) $display("FAIL cont_first_grant: got %b expected 01", bus.req_ready_o); else pass_cnt++;
    push_exp(0);
    @(negedge clk); #1;
    check_cnt++; if (bus.req_ready_o !== 2'b00) $display("FAIL cont_exec_ready: got %b expected 00", bus.req_ready_o); else pass_cnt++;
    @(negedge clk); #1;
    check_cnt++; if (bus.req_ready_o !== 2'b00) $display("FAIL cont_resp_ready: got %b expected 00", bus.req_ready_o); else pass_cnt++;
    check_cnt++;
    if (exp_q.size() == 0) $display("FAIL cont_rsp0: got %h expected <none queued>", rsp_word);
    else begin
      exp_v = exp_q.pop_front();
      if ({bus.rsp_valid_o, rsp_word} !== {1'b1, exp_v}) $display("FAIL cont_rsp0: got %b_%h expected 1_%h", bus.rsp_valid_o, rsp_word, exp_v);
      else pass_cnt++;
    end
    @(negedge clk); #1;
    check_cnt++; if (bus.req_ready_o !== 2'b10) $display("FAIL cont_second_grant: got %b expected 10", bus.req_ready_o); else pass_cnt++;
    push_exp(1);
    @(negedge clk);
    @(negedge clk); #1;
    check_cnt++;
    if (exp_q.size() == 0) $display("FAIL cont_rsp1: got %h expected <none queued>", rsp_word);
    else begin
      exp_v = exp_q.pop_front();
      if ({bus.rsp_valid_o, rsp_word} !== {1'b1, exp_v}) $display("FAIL cont_rsp1: got %b_%h expected 1_%h", bus.rsp_valid_o, rsp_word, exp_v);
      else pass_cnt++;
    end
    check_cnt++; if (bus.rsp_result_o !== 32'hFFFF_FFFE) $display("FAIL cont_sub_result: got %h expected fffffffe", bus.rsp_result_o); else pass_cnt++;
    @(negedge clk); #1;
    check_cnt++; if (bus.req_ready_o !== 2'b01) $display("FAIL cont_prio_back: got %b expected 01", bus.req_ready_o); else pass_cnt++;
    bus.req_valid_i = 2'b00;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    set_req(0, OP_SRA, 32'h8000_0000, 32'h0000_0024);
    bus.req_valid_i = 2'b01; #1;
    check_cnt++; if (bus.req_ready_o !== 2'b01) $display("FAIL bp_ready: got %b expected 01", bus.req_ready_o); else pass_cnt++;
    push_exp(0);
    @(negedge clk);
    set_req(1, OP_ADD, 32'd1, 32'd1);
    bus.req_valid_i = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check_cnt++;
      if (exp_q.size() == 0) $display("FAIL bp_hold: got %h expected <none queued>", rsp_word);
      else if ({bus.rsp_valid_o, rsp_word, bus.req_ready_o} !== {1'b1, exp_q[0], 2'b00})
        $display("FAIL bp_hold: cycle %0d got %b_%h_%b expected 1_%h_00", i, bus.rsp_valid_o, rsp_word, bus.req_ready_o, exp_q[0]);
      else pass_cnt++;
      check_cnt++; if (bus.rsp_result_o !== 32'hF800_0000) $display("FAIL bp_result: got %h expected f8000000", bus.rsp_result_o); else pass_cnt++;
    end
    @(negedge clk); bus.rsp_ready_i = 1'b1; #1;
    check_cnt++;
    if (exp_q.size() == 0) $display("FAIL bp_release: got %h expected <none queued>", rsp_word);
    else begin
      exp_v = exp_q.pop_front();
      if ({bus.rsp_valid_o, rsp_word, bus.req_ready_o} !== {1'b1, exp_v, 2'b00})
        $display("FAIL bp_release: got %b_%h_%b expected 1_%h_00", bus.rsp_valid_o, rsp_word, bus.req_ready_o, exp_v);
      else pass_cnt++;
    end
    @(negedge clk); #1;
    check_cnt++; if (bus.rsp_valid_o !== 1'b0) $display("FAIL bp_single_rsp: got %b expected 0", bus.rsp_valid_o); else pass_cnt++;
    check_cnt++; if (bus.req_ready_o !== 2'b10) $display("FAIL bp_next_grant: got %b expected 10", bus.req_ready_o); else pass_cnt++;
    bus.req_valid_i = 2'b00;
  endtask

  task automatic test_illegal_op();
    @(negedge clk);
    set_req(0, OP_BAD, $urandom, $urandom);
    bus.req_valid_i = 2'b01; #1;
    check_cnt++; if (bus.req_ready_o !== 2'b01) $display("FAIL ill_ready: got %b expected 01", bus.req_ready_o); else pass_cnt++;
    push_exp(0);
    @(negedge clk); bus.req_valid_i = 2'b00;
    @(negedge clk); #1;
    check_cnt++;
    if (exp_q.size() == 0) $display("FAIL ill_rsp: got %h expected <none queued>", rsp_word);
    else begin
      exp_v = exp_q.pop_front();
      if ({bus.rsp_valid_o, rsp_word} !== {1'b1, exp_v}) $display("FAIL ill_rsp: got %b_%h expected 1_%h", bus.rsp_valid_o, rsp_word, exp_v);
      else pass_cnt++;
    end
    check_cnt++;
    if ({bus_nc.rsp_valid_o, bus_nc.rsp_err_o} !== 2'b10)
      $display("FAIL ill_nocheck_err: got valid=%b err=%b expected valid=1 err=0", bus_nc.rsp_valid_o, bus_nc.rsp_err_o);
    else pass_cnt++;
    check_cnt++; if (dbg_state_nc !== 2'd2) $display("FAIL ill_nocheck_state: got %0d expected 2", dbg_state_nc); else pass_cnt++;
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    set_req(0, OP_ADD, $urandom, $urandom);
    bus.req_valid_i = 2'b01; #1;
    check_cnt++; if (bus.req_ready_o !== 2'b01) $display("FAIL rmf_ready: got %b expected 01", bus.req_ready_o); else pass_cnt++;
    @(negedge clk); bus.req_valid_i = 2'b00;
    @(negedge clk); #1;
    check_cnt++; if (bus.rsp_valid_o !== 1'b1) $display("FAIL rmf_in_resp: got %b expected 1", bus.rsp_valid_o); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; bus.rsp_ready_i = 1'b1; #1;
    check_cnt++;
    if ({bus.rsp_valid_o, rsp_word, dbg_state} !== '0)
      $display("FAIL rmf_dropped: got %b_%h_%0d expected 0_0_0", bus.rsp_valid_o, rsp_word, dbg_state);
    else pass_cnt++;
    set_req(1, OP_LTU, 32'd1, 32'd2);
    bus.req_valid_i = 2'b10; #1;
    check_cnt++; if (bus.req_ready_o !== 2'b10) $display("FAIL rmf_fresh_ready: got %b expected 10", bus.req_ready_o); else pass_cnt++;
    push_exp(1);
    @(negedge clk); bus.req_valid_i = 2'b00; #1;
    check_cnt++; if (bus.rsp_valid_o !== 1'b0) $display("FAIL rmf_exec_valid: got %b expected 0", bus.rsp_valid_o); else pass_cnt++;
    @(negedge clk); #1;
    check_cnt++;
    if (exp_q.size() == 0) $display("FAIL rmf_rsp: got %h expected <none queued>", rsp_word);
    else begin
      exp_v = exp_q.pop_front();
      if ({bus.rsp_valid_o, rsp_word} !== {1'b1, exp_v}) $display("FAIL rmf_rsp: got %b_%h expected 1_%h", bus.rsp_valid_o, rsp_word, exp_v);
      else pass_cnt++;
    end
    check_cnt++;
    if ({bus.rsp_result_o, bus.rsp_cmp_o} !== {32'd1, 1'b1})
      $display("FAIL rmf_ltu: got %h/%b expected 00000001/1", bus.rsp_result_o, bus.rsp_cmp_o);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int last_acc = -1;
    int n_acc = 0;
    bit new_ops = 1'b1;
    bus.rsp_ready_i = 1'b1;
    for (int cyc = 0; cyc < 36; cyc++) begin
      @(negedge clk);
      if (cyc < 30) begin
        if (new_ops) begin
          set_req(0, def_ops[$urandom_range(0, 15)], $urandom, $urandom);
          new_ops = 1'b0;
        end
        bus.req_valid_i = 2'b01;
      end else begin
        bus.req_valid_i = 2'b00;
      end
      #1;
      if (bus.req_ready_o[0]) begin
        if (last_acc >= 0) begin
          check_cnt++;
          if (cyc - last_acc != 3) $display("FAIL b2b_interval: got %0d expected 3", cyc - last_acc);
          else pass_cnt++;
        end
        last_acc = cyc;
        n_acc++;
        push_exp(0);
        new_ops = 1'b1;
      end
      if (bus.rsp_valid_o) begin
        check_cnt++;
        if (exp_q.size() == 0) $display("FAIL b2b_rsp: got %h expected <none queued>", rsp_word);
        else begin
          exp_v = exp_q.pop_front();
          if (rsp_word !== exp_v) $display("FAIL b2b_rsp: cycle %0d got %h expected %h", cyc, rsp_word, exp_v);
          else pass_cnt++;
        end
      end
    end
    check_cnt++; if (n_acc != 10) $display("FAIL b2b_accepts: got %0d expected 10", n_acc); else pass_cnt++;
    check_cnt++; if (exp_q.size() != 0) $display("FAIL b2b_drain: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid_i = 2'b00;
    bus.rsp_ready_i = 1'b0;
    set_req(0, 6'd0, 32'd0, 32'd0);
    set_req(1, 6'd0, 32'd0, 32'd0);
    test_reset();
    test_single_add();
    test_contention();
    test_backpressure();
    test_illegal_op();
    test_reset_midflight();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
